// File: rtl/sram_ctrl.sv
// sram_ctrl: burst read/write initiator for a single-port synchronous SRAM.
// Reads are issued against a 2-entry response buffer using credits, so host
// backpressure on rsp_ready never drops data returning from the SRAM.
module sram_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned LENW  = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned DW   = WIDTH * 8
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [LENW-1:0] req_len,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DW-1:0]   wr_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_last,
  output logic            op_done,
  output logic            sram_ce_b,
  output logic            sram_we_b,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_din,
  input  logic [DW-1:0]   sram_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t          state;
  logic [AW-1:0]   cur_addr;
  logic [AW-1:0]   next_addr;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q;
  logic [LENW-1:0] beats_left;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      buf_count;
  logic [DW-1:0]   data0;
  logic [DW-1:0]   data1;
  logic            last0;
  logic            last1;
  logic            pop;
  logic            push;
  logic [2:0]      occ;
  logic            issue_rd;
  logic            issue_wr;
  logic            issue;

  // Issue decode, credit check, address wrap and SRAM pin drive.
  always_comb begin
    pop       = (buf_count != 2'd0) && rsp_ready;
    push      = inflight;
    occ       = 3'(buf_count) + 3'(inflight);
    issue_rd  = (state == RD) && (occ < (3'd2 + 3'(pop)));
    // Writes wait until every outstanding read has drained out of the buffer.
    wr_ready  = (state == WR) && (buf_count == 2'd0) && !inflight;
    issue_wr  = wr_ready && wr_valid;
    issue     = issue_rd || issue_wr;
    next_addr = (cur_addr == AW'(DEPTH - 1)) ? '0 : cur_addr + AW'(1);

    req_ready = (state == IDLE);
    rsp_valid = (buf_count != 2'd0);
    rsp_data  = data0;
    rsp_last  = last0 && rsp_valid;
    op_done   = (issue_wr && (beats_left == '0)) || (pop && last0);
    sram_ce_b = !issue;
    sram_we_b = !issue_wr;
    sram_addr = issue ? cur_addr : addr_q;
    sram_din  = issue_wr ? wr_data : din_q;
  end

  // Command FSM: latch burst, step address/beat count per issued beat.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      cur_addr      <= '0;
      beats_left    <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (issue) addr_q <= cur_addr;
      if (issue_wr) din_q <= wr_data;
      inflight <= issue_rd;
      if (issue_rd) inflight_last <= (beats_left == '0);
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_addr   <= req_addr;
            beats_left <= req_len;
            state      <= req_write ? WR : RD;
          end
        end
        RD, WR: begin
          if (issue) begin
            cur_addr   <= next_addr;
            beats_left <= beats_left - LENW'(1);
            if (beats_left == '0) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry response FIFO; entry 0 is always the head seen by the host.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      buf_count <= 2'd0;
      data0     <= '0;
      data1     <= '0;
      last0     <= 1'b0;
      last1     <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_count == 2'd0) begin
            data0 <= sram_dout;
            last0 <= inflight_last;
          end else begin
            data1 <= sram_dout;
            last1 <= inflight_last;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          data0     <= data1;
          last0     <= last1;
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            data0 <= sram_dout;
            last0 <= inflight_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= sram_dout;
            last1 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed vectors for sram_ctrl against a behavioural SRAM.
module tb_sram_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned LENW  = 4;

  logic            clk = 1'b0;
  logic            rstb;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [LENW-1:0] req_len;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   wr_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic            op_done;
  logic            sram_ce_b;
  logic            sram_we_b;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din;
  logic [DW-1:0]   sram_dout;

  always #5 clk = ~clk;

  sram_ctrl #(.DEPTH(DEPTH), .WIDTH(1), .LENW(LENW)) dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .op_done(op_done),
    .sram_ce_b(sram_ce_b), .sram_we_b(sram_we_b), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Synchronous SRAM; preloaded with addr[7:0]^0x3C on the first edge.
  logic [DW-1:0] mem [DEPTH];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i) ^ 8'h3C;
      mem_init  <= 1'b1;
      sram_dout <= '0;
    end else if (!sram_ce_b) begin
      if (!sram_we_b) mem[sram_addr] <= sram_din;
      else            sram_dout      <= mem[sram_addr];
    end
  end

  // Pin and response activity log, sampled mid-cycle.
  int            ce_cnt = 0;
  int            we_cnt = 0;
  int            done_cnt = 0;
  int            bad_we = 0;
  int            rsp_n = 0;
  int            wn = 0;
  logic [DW-1:0] rdat  [64];
  logic          rlast [64];
  logic [AW-1:0] waddr [64];
  always @(negedge clk) begin
    if (!sram_ce_b) ce_cnt++;
    if (!sram_ce_b && !sram_we_b) begin
      we_cnt++;
      if (!wr_valid) bad_we++;
      if (wn < 64) waddr[wn] = sram_addr;
      wn++;
    end
    if (op_done) done_cnt++;
    if (rsp_valid && rsp_ready) begin
      if (rsp_n < 64) begin
        rdat[rsp_n]  = rsp_data;
        rlast[rsp_n] = rsp_last;
      end
      rsp_n++;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [LENW-1:0] l);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [DW-1:0] d, input logic gap);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 50) begin
      tick();
      n++;
    end
    check("wr_ready", 32'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    if (gap) tick();
  endtask

  int            d0, c0, w0, r0, b0, wn0;
  logic [11:0]   ce_vec, rv_vec;
  logic [DW-1:0] exp_d [4];

  initial begin
    rstb = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
    #3;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_wr_ready",  32'(wr_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_last",  32'(rsp_last), 0);
    check("rst_op_done",   32'(op_done), 0);
    check("rst_ce_b",      32'(sram_ce_b), 1);
    check("rst_we_b",      32'(sram_we_b), 1);
    check("rst_addr",      32'(sram_addr), 0);
    check("rst_din",       32'(sram_din), 0);
    tick(); tick();
    rstb = 1'b1;
    tick();

    // Single write then read-back of 0x010.
    d0 = done_cnt; c0 = ce_cnt; w0 = we_cnt; wn0 = wn;
    send_cmd(1'b1, 10'h010, 4'd0);
    send_wr(8'hA5, 1'b0);
    tick();
    check("t1_we_cycles", 32'(we_cnt - w0), 1);
    check("t1_ce_cycles", 32'(ce_cnt - c0), 1);
    check("t1_wr_done",   32'(done_cnt - d0), 1);
    check("t1_wr_addr",   32'(waddr[wn0]), 32'h010);
    rsp_ready = 1'b1;
    d0 = done_cnt;
    send_cmd(1'b0, 10'h010, 4'd0);
    check("t1_rd_ce",     32'(sram_ce_b), 0);
    check("t1_rd_we",     32'(sram_we_b), 1);
    check("t1_rd_addr",   32'(sram_addr), 32'h010);
    check("t1_valid_c0",  32'(rsp_valid), 0);
    tick();
    check("t1_valid_c1",  32'(rsp_valid), 0);
    tick();
    check("t1_valid_c2",  32'(rsp_valid), 1);
    check("t1_rsp_data",  32'(rsp_data), 32'hA5);
    check("t1_rsp_last",  32'(rsp_last), 1);
    check("t1_op_done",   32'(op_done), 1);
    tick();
    check("t1_valid_c3",  32'(rsp_valid), 0);
    check("t1_rd_done",   32'(done_cnt - d0), 1);

    // Read burst with the host stalled: only two credits may issue.
    rsp_ready = 1'b0;
    c0 = ce_cnt; r0 = rsp_n;
    send_cmd(1'b0, 10'h100, 4'd3);
    repeat (6) tick();
    check("t2_stall_issues", 32'(ce_cnt - c0), 2);
    check("t2_stall_ce_b",   32'(sram_ce_b), 1);
    check("t2_stall_valid",  32'(rsp_valid), 1);
    check("t2_stall_head",   32'(rsp_data), 32'h3C);
    d0 = done_cnt;
    rsp_ready = 1'b1;
    repeat (8) tick();
    check("t2_beats",  32'(rsp_n - r0), 4);
    check("t2_issues", 32'(ce_cnt - c0), 4);
    check("t2_done",   32'(done_cnt - d0), 1);
    for (int i = 0; i < 4; i++) begin
      check("t2_data", 32'(rdat[r0 + i]), 32'h3C + 32'(i));
      check("t2_last", 32'(rlast[r0 + i]), (i == 3) ? 1 : 0);
    end

    // Write burst across the top of memory, then read it back.
    wn0 = wn;
    send_cmd(1'b1, 10'(DEPTH - 2), 4'd3);
    send_wr(8'h11, 1'b0);
    send_wr(8'h22, 1'b0);
    send_wr(8'h33, 1'b0);
    send_wr(8'h44, 1'b0);
    tick();
    check("t3_waddr0", 32'(waddr[wn0]),     32'(DEPTH - 2));
    check("t3_waddr1", 32'(waddr[wn0 + 1]), 32'(DEPTH - 1));
    check("t3_waddr2", 32'(waddr[wn0 + 2]), 0);
    check("t3_waddr3", 32'(waddr[wn0 + 3]), 1);
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    r0 = rsp_n;
    send_cmd(1'b0, 10'(DEPTH - 2), 4'd3);
    repeat (8) tick();
    check("t3_beats", 32'(rsp_n - r0), 4);
    for (int i = 0; i < 4; i++) begin
      check("t3_data", 32'(rdat[r0 + i]), 32'(exp_d[i]));
      check("t3_last", 32'(rlast[r0 + i]), (i == 3) ? 1 : 0);
    end

    // Write burst with wr_valid gaps on alternate cycles.
    w0 = we_cnt; b0 = bad_we; d0 = done_cnt;
    send_cmd(1'b1, 10'h200, 4'd3);
    send_wr(8'h01, 1'b1);
    send_wr(8'h02, 1'b1);
    send_wr(8'h03, 1'b1);
    check("t4_done_early", 32'(done_cnt - d0), 0);
    send_wr(8'h04, 1'b1);
    check("t4_writes",  32'(we_cnt - w0), 4);
    check("t4_done",    32'(done_cnt - d0), 1);
    check("t4_we_gaps", 32'(bad_we - b0), 0);

    // Eight-beat read at full throughput.
    rsp_ready = 1'b1;
    r0 = rsp_n;
    send_cmd(1'b0, 10'h300, 4'd7);
    for (int cyc = 0; cyc < 12; cyc++) begin
      ce_vec[cyc] = sram_ce_b;
      rv_vec[cyc] = rsp_valid;
      tick();
    end
    check("t5_ce_pattern",    32'(ce_vec), 32'hF00);
    check("t5_valid_pattern", 32'(rv_vec), 32'h3FC);
    check("t5_beats",         32'(rsp_n - r0), 8);
    check("t5_data7",         32'(rdat[r0 + 7]), 32'h3B);
    check("t5_last7",         32'(rlast[r0 + 7]), 1);
    check("t5_last6",         32'(rlast[r0 + 6]), 0);

    // Reset in the middle of a read burst.
    send_cmd(1'b0, 10'h100, 4'd7);
    tick(); tick();
    rstb = 1'b0;
    #1;
    check("t6_ce_b",      32'(sram_ce_b), 1);
    check("t6_we_b",      32'(sram_we_b), 1);
    check("t6_rsp_valid", 32'(rsp_valid), 0);
    check("t6_rsp_last",  32'(rsp_last), 0);
    check("t6_req_ready", 32'(req_ready), 1);
    check("t6_op_done",   32'(op_done), 0);
    check("t6_addr",      32'(sram_addr), 0);
    d0 = done_cnt; r0 = rsp_n;
    tick();
    rstb = 1'b1;
    repeat (4) tick();
    check("t6_post_done",  32'(done_cnt - d0), 0);
    check("t6_post_beats", 32'(rsp_n - r0), 0);
    check("t6_post_ready", 32'(req_ready), 1);
    check("t6_post_valid", 32'(rsp_valid), 0);
    send_cmd(1'b0, 10'h010, 4'd0);
    tick(); tick();
    check("t6_new_valid", 32'(rsp_valid), 1);
    check("t6_new_data",  32'(rsp_data), 32'hA5);
    check("t6_new_last",  32'(rsp_last), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Initiator-side controller for the team's single-port synchronous SRAM. It accepts burst read/write commands from a host over valid/ready channels and drives the SRAM chip-enable, write-enable, address and data pins. It captures read data, which arrives one cycle after the request, into a 2-entry response buffer so the host can apply backpressure without losing data. It sits between a host/DMA engine and one SRAM instance with matching DEPTH and WIDTH.

Parameters:
DEPTH, 1024, SRAM word count; AW = $clog2(DEPTH) is the address width
WIDTH, 1, bytes per word; DW = WIDTH*8 is the data width
LENW, 4, burst length field width; maximum burst is 2**LENW beats

Ports:
clk  in  1  clock; all logic on posedge
rstb  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accept; high only in IDLE
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  AW  start address
req_len  in  LENW  beats minus 1
wr_valid  in  1  write data beat valid
wr_ready  out  1  write data accept
wr_data  in  DW  write data beat
rsp_valid  out  1  read data valid
rsp_ready  in  1  host accepts read data
rsp_data  out  DW  read data
rsp_last  out  1  final beat of the read burst
op_done  out  1  1-cycle pulse when a command completes
sram_ce_b  out  1  SRAM chip enable, active low
sram_we_b  out  1  SRAM write enable, active low
sram_addr  out  AW  SRAM address
sram_din  out  DW  SRAM write data
sram_dout  in  DW  SRAM read data; valid in the cycle after the read edge

Behaviour:
- Reset (rstb low, asynchronous): state=IDLE, response buffer empty, in-flight flag=0, beat counter=0.
- Outputs while in reset: req_ready=1, wr_ready=0, rsp_valid=0, rsp_last=0, op_done=0, sram_ce_b=1, sram_we_b=1, sram_addr=0, sram_din=0.
- FSM states: IDLE, RD, WR.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch addr into cur_addr, latch len into beats_left, go to RD or WR according to req_write.
- RD:
  - Define pop = rsp_valid&&rsp_ready.
  - A read beat issues when (buf_count + inflight - pop) < 2.
  - Issuing a beat means: sram_ce_b=0, sram_we_b=1, sram_addr=cur_addr (all combinational in that cycle).
  - At that edge: inflight<=1, cur_addr<=cur_addr+1 modulo DEPTH, beats_left decrements.
  - When no beat issues: inflight<=0.
  - Capture: one edge after an issue edge, sram_dout is pushed into the buffer together with a last flag (set on the final beat).
  - After the final issue, go to IDLE. The last capture and the draining of the buffer may overlap with IDLE and with a new command.
  - A new read command may issue immediately. A new write command stalls in WR until buf_count==0 and inflight==0.
- WR:
  - wr_ready=1.
  - On wr_valid: sram_ce_b=0, sram_we_b=0, sram_addr=cur_addr, sram_din=wr_data.
  - Address increments with wrap as in RD.
  - After the final beat, pulse op_done and go to IDLE.
- Idle pins: sram_ce_b=1 and sram_we_b=1 whenever no beat issues. sram_addr and sram_din hold their last values.
- Response buffer:
  - 2-entry FIFO, registered outputs.
  - rsp_valid=(buf_count!=0). rsp_data and rsp_last come from the head entry.
  - Simultaneous push and pop is legal. Push is never refused, because issue credits prevent overflow.
- Read op_done: pulses in the cycle the rsp_last beat is popped.
- Latency: a read command accepted at edge 0 issues in the following cycle, the SRAM samples at edge 1, and rsp_valid is high after edge 2.
- Throughput: 1 beat/cycle with rsp_ready held high.
- Wrap-around: an address beyond DEPTH-1 wraps to 0. For non-power-of-2 DEPTH, an explicit compare is required.
- Write followed by read to the same address returns the new data, by SRAM semantics.

Test Plan:
- Write addr 0x010 len 0 data 0xA5, then read 0x010 len 0 -> sram_ce_b/we_b low for one cycle; rsp_valid 2 cycles after read accept; rsp_data=0xA5; rsp_last=1; op_done pulses once per command.
- Read burst addr 0x100 len 3 with rsp_ready=0 -> exactly 2 beats issued, then sram_ce_b held 1. Release rsp_ready -> 4 beats 0x100..0x103 in order, rsp_last on the 4th only.
- Write burst addr DEPTH-2 len 3 (0x11,0x22,0x33,0x44), then read it back -> addresses DEPTH-2, DEPTH-1, 0, 1; data matches.
- Write burst len 3 with wr_valid low on alternate cycles -> sram_we_b low only on wr_valid cycles; 4 writes total; op_done after the 4th.
- Read burst len 7 with rsp_ready held high -> 8 consecutive sram_ce_b-low cycles; rsp_valid continuous for 8 cycles.
- Assert rstb mid read burst (after 2 beats) -> outputs at reset values immediately. After release: req_ready=1, rsp_valid=0, no op_done; a new command operates normally.
